// File: rtl/puf_race_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : puf_race_arbiter
// Purpose  : RO-PUF sequencer. For each oscillator pair it races two edge
//            counters and records which saturates first.
// Revision : 1.0 - initial release
// ============================================================================
module puf_race_arbiter #(
    parameter int SEL_W       = 5,
    parameter int N_BITS      = 16,
    parameter int CLR_CYC     = 4,
    parameter int TIMEOUT_CYC = 1 << 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  challenge,
    input  logic              finished_a,
    input  logic              finished_b,
    output logic              ctr_reset,
    output logic              ctr_enable,
    output logic [SEL_W-1:0]  sel_a,
    output logic [SEL_W-1:0]  sel_b,
    output logic [N_BITS-1:0] response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              tie_flag,
    output logic              timeout_flag
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state;
    logic               fa_meta;
    logic               fa_s;
    logic               fb_meta;
    logic               fb_s;
    logic [SEL_W-1:0]   base;
    logic [IDX_W-1:0]   idx;
    logic [CLR_W-1:0]   clr_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               won_a;
    logic               won_b;
    logic               run_exit;
    logic [IDX_W-1:0]   idx_next;
    logic [SEL_W-1:0]   next_pair;

    // Identical two-flop paths keep the A/B arrival order to one-cycle resolution.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fa_meta <= 1'b0;
            fa_s    <= 1'b0;
            fb_meta <= 1'b0;
            fb_s    <= 1'b0;
        end else begin
            fa_meta <= finished_a;
            fa_s    <= fa_meta;
            fb_meta <= finished_b;
            fb_s    <= fb_meta;
        end
    end

    assign run_exit  = fa_s | fb_s | (to_cnt == TO_LAST);
    assign idx_next  = idx + IDX_W'(1);
    assign next_pair = base + SEL_W'({idx_next, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            base         <= '0;
            idx          <= '0;
            clr_cnt      <= '0;
            to_cnt       <= '0;
            won_a        <= 1'b0;
            won_b        <= 1'b0;
            ctr_reset    <= 1'b1;
            ctr_enable   <= 1'b0;
            sel_a        <= '0;
            sel_b        <= '0;
            response     <= '0;
            resp_valid   <= 1'b0;
            busy         <= 1'b0;
            tie_flag     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base         <= challenge;
                        idx          <= '0;
                        clr_cnt      <= '0;
                        response     <= '0;
                        tie_flag     <= 1'b0;
                        timeout_flag <= 1'b0;
                        sel_a        <= challenge;
                        sel_b        <= challenge + SEL_W'(1);
                        busy         <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        ctr_reset  <= 1'b0;
                        ctr_enable <= 1'b1;
                        to_cnt     <= '0;
                        state      <= S_RUN;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end

                S_RUN: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // Capture the flags that ended the race; later arrivals must not turn it into a tie.
                    if (run_exit) begin
                        won_a      <= fa_s;
                        won_b      <= fb_s;
                        ctr_enable <= 1'b0;
                        state      <= S_DECIDE;
                    end
                end

                S_DECIDE: begin
                    response[idx] <= won_a & ~won_b;
                    if (won_a && won_b) begin
                        tie_flag <= 1'b1;
                    end
                    if (!won_a && !won_b) begin
                        timeout_flag <= 1'b1;
                    end
                    ctr_reset <= 1'b1;
                    if (idx == LAST_IDX) begin
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        idx     <= idx_next;
                        clr_cnt <= '0;
                        sel_a   <= next_pair;
                        sel_b   <= next_pair + SEL_W'(1);
                        state   <= S_CLEAR;
                    end
                end

                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    ctr_reset  <= 1'b1;
                    ctr_enable <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    a_no_reset_while_enabled : assert property (
        @(posedge clk) disable iff (reset) !(ctr_reset && ctr_enable));

    a_valid_implies_busy : assert property (
        @(posedge clk) disable iff (reset) resp_valid |-> busy);

    a_response_held : assert property (
        @(posedge clk) disable iff (reset)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(response)));

endmodule
`default_nettype wire

// File: tb/tb_puf_race_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_race_arbiter
// Purpose  : Scoreboard bench: counter model, race-outcome reference, monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_race_arbiter;

    localparam int SEL_W       = 5;
    localparam int N_BITS      = 4;
    localparam int CLR_CYC     = 2;
    localparam int TIMEOUT_CYC = 50;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [SEL_W-1:0]  challenge = '0;
    logic              finished_a = 1'b0;
    logic              finished_b = 1'b0;
    logic              ctr_reset;
    logic              ctr_enable;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [N_BITS-1:0] response;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              busy;
    logic              tie_flag;
    logic              timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int ka[N_BITS];
    int kb[N_BITS];

    typedef struct {
        logic [N_BITS-1:0] resp;
        logic              tie;
        logic              to;
    } resp_t;

    typedef struct {
        logic [SEL_W-1:0] sa;
        logic [SEL_W-1:0] sb;
        int               len;
    } bit_t;

    resp_t resp_q[$];
    bit_t  bit_q[$];

    puf_race_arbiter #(
        .SEL_W(SEL_W), .N_BITS(N_BITS), .CLR_CYC(CLR_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .finished_a(finished_a), .finished_b(finished_b),
        .ctr_reset(ctr_reset), .ctr_enable(ctr_enable),
        .sel_a(sel_a), .sel_b(sel_b), .response(response),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy),
        .tie_flag(tie_flag), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // A flag counts only if its synchronized copy is seen within the RUN window.
    function automatic bit fin_ok(input int k);
        return (k >= 1) && (k <= TIMEOUT_CYC - 2);
    endfunction

    // 1 = A wins, 0 = B wins, 2 = tie, 3 = timeout
    function automatic int outcome(input int a, input int b);
        if (fin_ok(a) && fin_ok(b)) return (a < b) ? 1 : ((a > b) ? 0 : 2);
        if (fin_ok(a)) return 1;
        if (fin_ok(b)) return 0;
        return 3;
    endfunction

    function automatic int run_len(input int a, input int b);
        if (fin_ok(a) && fin_ok(b)) return ((a < b) ? a : b) + 2;
        if (fin_ok(a)) return a + 2;
        if (fin_ok(b)) return b + 2;
        return TIMEOUT_CYC;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ctr_reset"}, 32'(ctr_reset), 32'(1));
        check({tag, "_ctr_enable"}, 32'(ctr_enable), 32'(0));
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_tie_flag"}, 32'(tie_flag), 32'(0));
        check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(0));
        check({tag, "_sel_a"}, 32'(sel_a), 32'(0));
        check({tag, "_sel_b"}, 32'(sel_b), 32'(0));
        check({tag, "_response"}, 32'(response), 32'(0));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    task automatic run_eval(input logic [SEL_W-1:0] ch, input int hold, input bit abort);
        resp_t            er;
        bit_t             eb;
        int               code;
        logic [SEL_W-1:0] pair1;
        wait_idle();
        er.resp = '0;
        er.tie  = 1'b0;
        er.to   = 1'b0;
        for (int b = 0; b < N_BITS; b++) begin
            code       = outcome(ka[b], kb[b]);
            er.resp[b] = (code == 1);
            if (code == 2) er.tie = 1'b1;
            if (code == 3) er.to  = 1'b1;
            eb.sa  = ch + SEL_W'(2 * b);
            eb.sb  = ch + SEL_W'(2 * b + 1);
            eb.len = run_len(ka[b], kb[b]);
            bit_q.push_back(eb);
        end
        if (!abort) resp_q.push_back(er);
        resp_ready = (hold == 0);
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (abort) begin
            pair1 = ch + SEL_W'(2);
            for (int t = 0; t < 2000 && !(ctr_enable && sel_a == pair1); t++) @(negedge clk);
            check("abort_run_reached", 32'(ctr_enable), 32'(1));
            @(posedge clk);
            #2 reset = 1'b1;
            #1 check_reset_values("abort");
            @(posedge clk);
            @(posedge clk);
            #2 reset = 1'b0;
            return;
        end
        for (int t = 0; t < 2000 && !resp_valid; t++) @(negedge clk);
        check("resp_valid_seen", 32'(resp_valid), 32'(1));
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                check("hold_valid", 32'(resp_valid), 32'(1));
                check("hold_response", 32'(response), 32'(er.resp));
                check("hold_busy", 32'(busy), 32'(1));
                start     = 1'b1;
                challenge = ~ch;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            start      = 1'b0;
            resp_ready = 1'b1;
        end
    endtask

    // Edge-counter model: finished_x rises after kx enabled cycles, clears on ctr_reset.
    initial begin : counter_model
        int   runs;
        int   cur;
        int   cnt;
        logic prev_en;
        runs = 0; cur = 0; cnt = 0; prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) runs = 0;
            if (ctr_enable && !prev_en) begin
                cur = runs;
                runs++;
            end
            prev_en = ctr_enable;
            if (ctr_reset) begin
                cnt = 0;
                finished_a = 1'b0;
                finished_b = 1'b0;
            end else if (ctr_enable) begin
                cnt++;
                if (cur < N_BITS) begin
                    if (cnt == ka[cur]) finished_a = 1'b1;
                    if (cnt == kb[cur]) finished_b = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        bit               in_run;
        int               len;
        logic [SEL_W-1:0] sa;
        logic [SEL_W-1:0] sb;
        bit               moved;
        bit_t             eb;
        resp_t            er;
        in_run = 1'b0; len = 0; sa = '0; sb = '0; moved = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bit_q.delete();
                in_run = 1'b0;
            end else begin
                if (ctr_enable) begin
                    if (!in_run) begin
                        in_run = 1'b1;
                        len    = 0;
                        sa     = sel_a;
                        sb     = sel_b;
                        moved  = 1'b0;
                    end else if (sel_a !== sa || sel_b !== sb) begin
                        moved = 1'b1;
                    end
                    len++;
                end else if (in_run) begin
                    in_run = 1'b0;
                    if (bit_q.size() == 0) begin
                        check("unexpected_run", 32'(1), 32'(0));
                    end else begin
                        eb = bit_q.pop_front();
                        check("sel_a", 32'(sa), 32'(eb.sa));
                        check("sel_b", 32'(sb), 32'(eb.sb));
                        check("run_len", 32'(len), 32'(eb.len));
                        check("sel_stable", 32'(moved), 32'(0));
                    end
                end
                if (resp_valid && resp_ready) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_response", 32'(1), 32'(0));
                    end else begin
                        er = resp_q.pop_front();
                        check("response", 32'(response), 32'(er.resp));
                        check("tie_flag", 32'(tie_flag), 32'(er.tie));
                        check("timeout_flag", 32'(timeout_flag), 32'(er.to));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        for (int b = 0; b < N_BITS; b++) begin ka[b] = 0; kb[b] = 0; end
        repeat (3) @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #2 reset = 1'b0;

        for (int b = 0; b < N_BITS; b++) begin ka[b] = 10; kb[b] = 20; end
        run_eval(5'd6, 0, 1'b0);

        ka[1] = 20; kb[1] = 10; ka[3] = 20; kb[3] = 10;
        run_eval(5'd6, 0, 1'b0);

        for (int b = 0; b < N_BITS; b++) begin ka[b] = 10; kb[b] = 20; end
        ka[2] = 7; kb[2] = 7;
        run_eval(5'd6, 0, 1'b0);

        ka[0] = 5; kb[0] = 3; ka[1] = 4; kb[1] = 9; ka[2] = 12; kb[2] = 2; ka[3] = 1; kb[3] = 30;
        run_eval(5'd31, 0, 1'b0);

        ka[0] = 0;  kb[0] = 0;
        ka[1] = TIMEOUT_CYC - 2; kb[1] = 0;
        ka[2] = TIMEOUT_CYC - 1; kb[2] = 0;
        ka[3] = 0;  kb[3] = TIMEOUT_CYC - 2;
        run_eval(5'd0, 0, 1'b0);

        for (int b = 0; b < N_BITS; b++) begin ka[b] = 3 + b; kb[b] = 6 - b; end
        run_eval(5'd12, 5, 1'b0);

        for (int b = 0; b < N_BITS; b++) begin ka[b] = 30; kb[b] = 35; end
        run_eval(5'd3, 0, 1'b1);

        for (int n = 0; n < 10; n++) begin
            for (int b = 0; b < N_BITS; b++) begin
                ka[b] = int'($urandom_range(0, TIMEOUT_CYC));
                kb[b] = int'($urandom_range(0, TIMEOUT_CYC));
                if ($urandom_range(0, 5) == 0) kb[b] = ka[b];
            end
            run_eval(SEL_W'($urandom_range(0, 31)), 0, 1'b0);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'(0));
        check("bit_queue_drained", 32'(bit_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/puf_race_arbiter.md
# puf_race_arbiter

Sequencing controller for the parallel RO PUF datapath; consumes the `finished` flags of two post-mux edge counters and produces one response bit per oscillator pair. For each bit it:
- selects an oscillator pair;
- clears and enables both counters;
- records which counter saturates first.

It assembles an N_BITS response word and returns it over a valid/ready handshake. It sits between the challenge source (host or UART) and the pair of counter/mux slices.

## Interface
- `SEL_W`, default 5: width of each oscillator-mux select.
- `N_BITS`, default 16: response bits per evaluation.
- `CLR_CYC`, default 4: cycles `ctr_reset` is held per bit (min 1).
- `TIMEOUT_CYC`, default 2^24: RUN-state cycle limit per bit.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin evaluation; sampled only in IDLE.
- `challenge`, input, SEL_W: base oscillator index; latched on accepted `start`.
- `finished_a`, `finished_b`, input, 1 each: counter saturation flags. Asynchronous to `clk`, since the counters run in oscillator domains.
- `ctr_reset`, output, 1: reset to both counters.
- `ctr_enable`, output, 1: enable to both counters.
- `sel_a`, `sel_b`, output, SEL_W each: mux selects for the current pair.
- `response`, output, N_BITS: assembled response word.
- `resp_valid`, output, 1: response available.
- `resp_ready`, input, 1: consumer accepts the response.
- `busy`, output, 1: high in every state except IDLE.
- `tie_flag`, output, 1: sticky per evaluation; some bit saw both counters finish in the same cycle.
- `timeout_flag`, output, 1: sticky per evaluation; some bit timed out.

## Operation
- `finished_a` and `finished_b` each pass through a 2-flop synchronizer (`fa_s`, `fb_s`). Both paths are identical, so ordering is preserved to one-cycle resolution.
- **IDLE:**
  - `ctr_reset`=1 and `ctr_enable`=0.
  - On `start`=1: latch `challenge` into `base`, set bit index `i`=0, clear `response`, `tie_flag` and `timeout_flag`, then go to CLEAR.
- **CLEAR:**
  - `sel_a` = `base`+2i and `sel_b` = `base`+2i+1, both mod 2^SEL_W (wrap-around allowed).
  - `ctr_reset`=1 and `ctr_enable`=0 for exactly CLR_CYC cycles, then go to RUN.
- **RUN:**
  - `ctr_reset`=0 and `ctr_enable`=1; the timeout counter increments each cycle.
  - Exit when `fa_s` or `fb_s` is 1, or when the timeout counter reaches TIMEOUT_CYC-1; then go to DECIDE.
- **DECIDE** (1 cycle): `ctr_enable`=0, and `response[i]` is written as follows:
  - `fa_s`=1 and `fb_s`=0: bit = 1.
  - `fa_s`=0 and `fb_s`=1: bit = 0.
  - Both 1: bit = 0 and set `tie_flag`.
  - Neither (timeout): bit = 0 and set `timeout_flag`.
  - A finish and the timeout in the same cycle: the finish wins and `timeout_flag` is not set.
  - Next state: if `i`=N_BITS-1, go to DONE; otherwise increment `i` and go to CLEAR.
- **DONE:**
  - `resp_valid`=1; `response` and both flags are held stable.
  - `ctr_reset`=1.
  - The handshake completes when `resp_valid` and `resp_ready` are both 1; go to IDLE next cycle with `resp_valid`=0.
- `start` is ignored outside IDLE.
- `response` and the flags remain readable in IDLE until the next accepted `start`.
- Reset asserted mid-operation aborts immediately: all state and outputs return to reset values, and no partial response is presented.
- Reset values:
  - `ctr_reset`=1.
  - `ctr_enable`=0, `resp_valid`=0, `busy`=0, `tie_flag`=0, `timeout_flag`=0.
  - `sel_a`=0, `sel_b`=0, `response`=0.
  - State = IDLE, synchronizers = 0.

## Timing
- `start` is accepted at edge T.
- CLEAR occupies cycles T+1 .. T+CLR_CYC; RUN begins at cycle T+CLR_CYC+1.
- `sel_a`/`sel_b` update at CLEAR entry and are stable through CLEAR, RUN and DECIDE.
- A raw `finished` edge reaches `fa_s`/`fb_s` 2 edges later. If RUN sees the flag at cycle R:
  - DECIDE is at R+1;
  - `response[i]` is visible at R+2;
  - the next CLEAR (or DONE) starts at R+2.
- The timeout path: RUN lasts exactly TIMEOUT_CYC cycles, followed by DECIDE.
- `resp_valid` rises on the cycle DONE is entered. With `resp_ready` already 1 it is high for exactly one cycle.
- Minimum evaluation, from `start` to `resp_valid`: N_BITS × (CLR_CYC + 2 + 2) + 1 cycles, with each finish arriving on the first RUN cycle.

## Test plan
- N_BITS=4, CLR_CYC=2, `challenge`=6. A counter model raises `finished_a` 10 cycles into RUN and `finished_b` at 20, for every pair. Required: `sel_a`/`sel_b` step through 6/7, 8/9, 10/11, 12/13; `response`=4'b1111; `resp_valid` rises; both flags are 0.
- Same setup with B faster on bits 1 and 3. Required: `response`=4'b0101.
- Both `finished` inputs rise in the same cycle on bit 2. Required: `response[2]`=0 and `tie_flag`=1.
- `challenge`=31, SEL_W=5. Required: bit 0 pair is 31/0 and bit 1 pair is 1/2 (wrap).
- TIMEOUT_CYC=50 with no finish on bit 0. Required: RUN lasts 50 cycles; `response[0]`=0 and `timeout_flag`=1. Also, a finish landing on timeout cycle 49 gives a normal bit with no flag.
- `resp_ready` held 0 for 5 cycles in DONE. Required: `resp_valid` and `response` stay stable and `start` is ignored. Separately, `reset` pulsed during RUN of bit 1 returns every output to its reset value the same cycle.
